// File: rtl/digit_sequence_detector.sv
// Sliding-window detector for a fixed sequence of digits, with overlapping or non-overlapping
// detection. Define SEQDET_MATCH_COUNT_EN to build the saturating match_count output.
module digit_sequence_detector #(
    parameter int unsigned                     DIGIT_W = 4,
    parameter int unsigned                     SEQ_LEN = 4,
    parameter logic [DIGIT_W*SEQ_LEN-1:0]      PATTERN = 16'h1094
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               valid,
    input  logic [DIGIT_W-1:0]                 number,
    input  logic                               overlap_en,
    output logic                               pattern,
    output logic [$clog2(SEQ_LEN+1)-1:0]       fill
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    output logic [7:0]                         match_count
`endif
);

    localparam int unsigned HIST_W = DIGIT_W * SEQ_LEN;
    localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    logic [HIST_W-1:0] history_q, history_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              pattern_q, pattern_d;

    logic [HIST_W-1:0] history_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              match;

    // Oldest digit falls off the top; the new digit enters the bottom slice.
    assign history_shift = {history_q[HIST_W-DIGIT_W-1:0], number};
    assign fill_inc      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign match         = valid && (history_shift == PATTERN) && (fill_inc == FILL_FULL);

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = match;
        if (valid) begin
            if (match && !overlap_en) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = history_shift;
                fill_d    = fill_inc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
        end
    end

    assign pattern = pattern_q;
    assign fill    = fill_q;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [7:0] match_count_q, match_count_d;

    always_comb begin
        match_count_d = match_count_q;
        if (match && (match_count_q != 8'hFF)) begin
            match_count_d = match_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_count_q <= 8'd0;
        end else begin
            match_count_q <= match_count_d;
        end
    end

    assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_digit_sequence_detector.sv
// Directed bench for digit_sequence_detector: dut_a uses default parameters, dut_b PATTERN 16'h1212.
module tb_digit_sequence_detector;

    logic       clock;
    logic       reset_n;
    logic       valid;
    logic [3:0] number;
    logic       overlap_en;

    logic       a_pattern, b_pattern;
    logic [2:0] a_fill, b_fill;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [7:0] a_count, b_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    digit_sequence_detector dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .valid      (valid),
        .number     (number),
        .overlap_en (overlap_en),
        .pattern    (a_pattern),
        .fill       (a_fill)
`ifdef SEQDET_MATCH_COUNT_EN
        ,
        .match_count(a_count)
`endif
    );

    digit_sequence_detector #(
        .DIGIT_W (4),
        .SEQ_LEN (4),
        .PATTERN (16'h1212)
    ) dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .valid      (valid),
        .number     (number),
        .overlap_en (overlap_en),
        .pattern    (b_pattern),
        .fill       (b_fill)
`ifdef SEQDET_MATCH_COUNT_EN
        ,
        .match_count(b_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of input, then sample at the following falling edge.
    task automatic step(input logic v, input logic [3:0] d);
        valid  = v;
        number = d;
        @(posedge clock);
        @(negedge clock);
        valid = 1'b0;
        pulses_a += int'(a_pattern);
        pulses_b += int'(b_pattern);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        pulses_a = 0;
        pulses_b = 0;
    endtask

    initial begin
        reset_n    = 1'b0;
        valid      = 1'b0;
        number     = 4'd0;
        overlap_en = 1'b1;
        @(negedge clock);
        check_eq("reset_pattern", 32'(a_pattern), 0);
        check_eq("reset_fill", 32'(a_fill), 0);
        reset_n = 1'b1;

        // Basic 1,0,9,4.
        step(1'b1, 4'd1); check_eq("basic_fill1", 32'(a_fill), 1);
        step(1'b1, 4'd0);
        step(1'b1, 4'd9); check_eq("basic_p_before", 32'(a_pattern), 0);
        step(1'b1, 4'd4); check_eq("basic_pulse", 32'(a_pattern), 1);
        check_eq("basic_fill4", 32'(a_fill), 4);
        step(1'b0, 4'd4); check_eq("basic_pulse_end", 32'(a_pattern), 0);
        check_eq("basic_fill_hold", 32'(a_fill), 4);

        // Gap of 5 idle cycles mid-sequence; a 4 on the bus with valid=0 is ignored.
        do_reset();
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd4);
        check_eq("gap_fill_hold", 32'(a_fill), 2);
        check_eq("gap_no_pulse", pulses_a, 0);
        step(1'b1, 4'd9);
        step(1'b1, 4'd4); check_eq("gap_pulse", 32'(a_pattern), 1);
        step(1'b0, 4'd0);
        check_eq("gap_pulse_count", pulses_a, 1);

        // Overlapping 1,2,1,2,1,2 on dut_b.
        do_reset();
        overlap_en = 1'b1;
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd1);
        step(1'b1, 4'd2); check_eq("ovl_pulse4", 32'(b_pattern), 1);
        step(1'b1, 4'd1); check_eq("ovl_nopulse5", 32'(b_pattern), 0);
        step(1'b1, 4'd2); check_eq("ovl_pulse6", 32'(b_pattern), 1);
        check_eq("ovl_pulses", pulses_b, 2);
        check_eq("ovl_fill_sat", 32'(b_fill), 4);

        // Non-overlapping 1,2,1,2,1,2 on dut_b.
        do_reset();
        overlap_en = 1'b0;
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd1);
        step(1'b1, 4'd2); check_eq("novl_pulse4", 32'(b_pattern), 1);
        check_eq("novl_fill_clr", 32'(b_fill), 0);
        step(1'b1, 4'd1); step(1'b1, 4'd2);
        check_eq("novl_pulses", pulses_b, 1);
        check_eq("novl_fill_end", 32'(b_fill), 2);

        // Sliding window: 1,1,0,9,4.
        do_reset();
        overlap_en = 1'b1;
        step(1'b1, 4'd1); step(1'b1, 4'd1); step(1'b1, 4'd0); step(1'b1, 4'd9);
        step(1'b1, 4'd4); check_eq("slide_pulse", 32'(a_pattern), 1);
        check_eq("slide_pulses", pulses_a, 1);

        // Asynchronous reset mid-sequence.
        do_reset();
        step(1'b1, 4'd1); step(1'b1, 4'd0); step(1'b1, 4'd9);
        #2 reset_n = 1'b0;
        #1 check_eq("async_fill", 32'(a_fill), 0);
        check_eq("async_pattern", 32'(a_pattern), 0);
        @(negedge clock);
        reset_n  = 1'b1;
        pulses_a = 0;
        step(1'b1, 4'd4);
        check_eq("post_rst_nopulse", 32'(a_pattern), 0);
        check_eq("post_rst_fill", 32'(a_fill), 1);

        // 300 non-overlapping matches on dut_a.
        do_reset();
        overlap_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'd1); step(1'b1, 4'd0); step(1'b1, 4'd9); step(1'b1, 4'd4);
`ifdef SEQDET_MATCH_COUNT_EN
            if (i == 0) check_eq("count_first", 32'(a_count), 1);
`endif
        end
        check_eq("many_pulses", pulses_a, 300);
`ifdef SEQDET_MATCH_COUNT_EN
        check_eq("count_sat", 32'(a_count), 255);
        do_reset();
        check_eq("count_reset", 32'(a_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
